alu_adder_pipe: RTL and testbench
=================================

Name: alu_adder_pipe

Overview:
- Parametrised, carry-pipelined add/subtract unit with flags and tag pass-through.
- Replaces the single-cycle 32-bit ALU adder where the adder carry chain limits clock frequency.
- Splits the carry chain into STAGES equal segments, one segment per register stage.
- Uses a valid/ready handshake on input and output, plus a synchronous flush for CPU pipeline kills.

Parameters:
- WIDTH, 32, operand/result width; must be divisible by STAGES.
- STAGES, 2, pipeline depth and carry-chain segment count; 1 ≤ STAGES ≤ WIDTH.
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted this cycle when in_valid & in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B (implemented as A + ~B + 1).
- in_sign  in  1  1 = signed flag semantics, 0 = unsigned.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result when out_valid & out_ready.
- out_s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- out_z  out  1  out_s == 0.
- out_v  out  1  overflow; meaning depends on in_sign (see Behaviour).
- out_n  out  1  negative/less-than flag.
- out_c  out  1  raw carry out of the MSB.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits, out_valid and all output data/flag registers clear to 0.
  - Reset asserted mid-operation discards every in-flight operation.
  - in_ready is 0 while reset is low.
- Segments:
  - SEG = WIDTH/STAGES.
  - Stage k (0-based) computes bits [k*SEG +: SEG] from the registered operands and the registered carry-in of stage k-1.
  - Stage 0 carry-in = in_sub.
  - Upper operand bits travel with the operation.
  - Partial sum bits already computed are held in the stage register.
- Advance rule (global stall):
  - en = ~out_valid | out_ready.
  - When en, every stage register loads from its predecessor.
  - When ~en, all stages hold.
  - Bubbles are not collapsed.
- in_ready = en & ~flush & reset. An operation is captured into stage 0 on the edge where in_valid & in_ready.
- Latency and throughput:
  - Exactly STAGES cycles from the accepting edge to out_valid with no stall.
  - One operation per cycle sustained.
  - Results emerge in acceptance order.
- Output hold: while out_valid & ~out_ready, out_s, all flags and out_tag are held stable.
- Flags, computed in the final stage from the full result and registered with it:
  - z = (s == 0), all modes.
  - c = carry out of bit WIDTH-1 of A + (B ^ {WIDTH{sub}}) + sub.
  - Signed (in_sign=1):
    - v = (a_msb == bx_msb) & (s_msb != a_msb), where bx = B ^ {WIDTH{sub}}.
    - n = s_msb ^ v, the true sign, usable directly for slt.
  - Unsigned (in_sign=0):
    - Add: v = c and n = 0.
    - Sub: v = ~c (borrow) and n = ~c (A < B).
- Flush (flush=1 at a clock edge):
  - All stage valid bits and out_valid clear, regardless of en and out_ready.
  - A simultaneous in_valid is not accepted (in_ready=0).
  - Data registers may keep stale values; only valid bits matter.
- STAGES=1: a single register stage; behaves as a registered 1-cycle adder with the same handshake.
- The full carry never ripples through more than SEG bits per cycle; no combinational path exists from in_* to out_*.
- Combinational paths:
  - in_ready depends combinationally on out_ready, out_valid and flush; this path is allowed.
  - out_valid does not depend combinationally on in_valid.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op encodings ADD=0, SUB=1.
  - The flag bundle order {z,v,n,c}.
  - The elaboration check (WIDTH % STAGES == 0).
- One natural sub-module, alu_adder_seg: SEG-bit adder slice with cin/cout and its stage register, instantiated STAGES times via generate.
- The top level handles the handshake, flags and flush.

Test Plan (WIDTH=32, STAGES=2, out_ready=1 unless noted):
- Signed add, A=0x7FFFFFFF, B=0x00000001, accepted at edge 0 → out_valid at edge 2; s=0x80000000, v=1, n=0, z=0, c=0.
- Unsigned sub, A=3, B=5 → s=0xFFFFFFFE, c=0, v=1, n=1, z=0. Then sub, A=5, B=5 → s=0, z=1, c=1, v=0, n=0.
- Segment-boundary carry, add A=0x0000FFFF, B=0x00000001 → s=0x00010000, c=0. Then add A=0xFFFFFFFF, B=1 unsigned → s=0, z=1, c=1, v=1.
- Backpressure: 4 back-to-back adds with tags 1..4, out_ready=0 for 3 cycles after the first out_valid → in_ready drops, no loss or duplication, tags emerge 1,2,3,4, held data stable during the stall.
- Flush: 2 ops in flight, flush pulsed with in_valid=1 → out_valid stays 0 for the next 2 cycles, the flushed op is not accepted, and the next op has latency 2.
- reset low mid-flight for 1 cycle → out_valid=0 and outputs=0 immediately (asynchronously); after release, normal operation with latency 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the carry-pipelined add/subtract unit:
// operation encoding, flag bundle layout and the configuration check.
package alu_pkg;

  // Operation encoding: the sub bit doubles as the stage-0 carry-in.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  // Flag bundle, MSB first: {z, v, n, c}.
  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } alu_flags_t;

  // A legal configuration splits the operand into STAGES equal,
  // non-empty carry-chain segments.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/alu_adder_seg.sv
// One carry-chain segment: a SEG-bit adder with carry-in/carry-out and
// the stage register that holds this segment's sum bits once computed.
// The combinational sum is also exposed so the final segment's result
// can feed the flag logic in the same cycle it is registered.
module alu_adder_seg
  import alu_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_bx,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum_d,
  output logic           o_cout,
  output logic [SEG-1:0] o_sum_q
);

  logic [SEG:0]   w_sum;
  logic [SEG-1:0] r_sum;

  // The carry ripples through this segment only, never beyond SEG bits.
  assign w_sum   = {1'b0, i_a} + {1'b0, i_bx} + {{SEG{1'b0}}, i_cin};
  assign o_sum_d = w_sum[SEG-1:0];
  assign o_cout  = w_sum[SEG];
  assign o_sum_q = r_sum;

  // Stage register for this segment's sum; holds while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_sum[SEG-1:0];
    end
  end

endmodule

// File: rtl/alu_adder_pipe.sv
// Carry-pipelined add/subtract unit with {z,v,n,c} flags and an opaque tag.
//
// Pipeline layout (index = register boundary):
//   0         : capture register (operands, B already conditionally inverted,
//               stage-0 carry-in = sub, sign mode, tag)
//   k+1       : after segment k has added bits [k*SEG +: SEG]
//   STAGES    : output register (full sum, flags, tag)
// An operation accepted on edge E is presented on out_* after edge E+STAGES.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. All stages advance together when en = ~out_valid | out_ready and hold
// otherwise (bubbles are not squeezed out). in_ready = en & ~flush & reset, so
// it depends combinationally on out_ready/out_valid/flush only; out_valid is a
// pure register output. flush clears every valid bit on the next edge.
module alu_adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sign,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_z,
  output logic             out_v,
  output logic             out_n,
  output logic             out_c,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("alu_adder_pipe: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  // Global advance enable shared by every stage.
  logic w_en;

  // Valid bits and tag travel through every boundary including the output.
  logic             r_vld [0:STAGES];
  logic [TAG_W-1:0] r_tag [0:STAGES];

  // Operand/control state needed by the segments still to be computed.
  logic [WIDTH-1:0] r_a    [0:LAST];
  logic [WIDTH-1:0] r_bx   [0:LAST];
  alu_op_e          r_op   [0:LAST];
  logic             r_sign [0:LAST];
  logic             r_cin  [0:LAST];

  // Lower sum bits already produced by earlier segments, delayed so they
  // line up with the operation. r_lo[k] holds bits below (k-1)*SEG.
  logic [WIDTH-1:0] r_lo [1:STAGES];

  alu_flags_t r_flags;

  // Segment outputs.
  logic [SEG-1:0] w_sum_d [0:LAST];
  logic [SEG-1:0] w_sum_q [0:LAST];
  logic           w_cout  [0:LAST];

  // Registered partial sum visible at each boundary (bits of finished segments).
  logic [WIDTH-1:0] w_ps [0:STAGES];

  // Full result and flags formed in the final segment's cycle.
  logic [WIDTH-1:0] w_s_fin;
  alu_flags_t       w_flags;
  logic             w_s_msb;
  logic             w_a_msb;
  logic             w_bx_msb;

  assign w_en     = ~r_vld[STAGES] | out_ready;
  assign in_ready = w_en & ~flush & reset;

  assign w_ps[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    alu_adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .clk     (clk),
      .rst_n   (reset),
      .i_en    (w_en),
      .i_a     (r_a[k][k*SEG +: SEG]),
      .i_bx    (r_bx[k][k*SEG +: SEG]),
      .i_cin   (r_cin[k]),
      .o_sum_d (w_sum_d[k]),
      .o_cout  (w_cout[k]),
      .o_sum_q (w_sum_q[k])
    );

    // r_lo[k+1] only carries bits below k*SEG, so OR-ing in the segment is exact.
    assign w_ps[k+1] = r_lo[k+1] | (WIDTH'(w_sum_q[k]) << (k * SEG));
  end

  assign w_s_fin  = w_ps[LAST] | (WIDTH'(w_sum_d[LAST]) << (LAST * SEG));
  assign w_s_msb  = w_s_fin[WIDTH-1];
  assign w_a_msb  = r_a[LAST][WIDTH-1];
  assign w_bx_msb = r_bx[LAST][WIDTH-1];

  // Flags from the full result; signed mode reports the true sign in n.
  always_comb begin
    w_flags   = '0;
    w_flags.z = (w_s_fin == '0);
    w_flags.c = w_cout[LAST];
    if (r_sign[LAST]) begin
      w_flags.v = (w_a_msb == w_bx_msb) & (w_s_msb != w_a_msb);
      w_flags.n = w_s_msb ^ w_flags.v;
    end else if (r_op[LAST] == OP_SUB) begin
      w_flags.v = ~w_cout[LAST];
      w_flags.n = ~w_cout[LAST];
    end else begin
      w_flags.v = w_cout[LAST];
      w_flags.n = 1'b0;
    end
  end

  // Valid pipeline: flush kills everything in flight, otherwise shift on en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_vld[k] <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_vld[k] <= 1'b0;
      end
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k+1] <= r_vld[k];
      end
    end
  end

  // Data pipeline: advances with en; stale contents behind a flush are harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_tag[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]    <= '0;
        r_bx[k]   <= '0;
        r_op[k]   <= OP_ADD;
        r_sign[k] <= 1'b0;
        r_cin[k]  <= 1'b0;
        r_lo[k+1] <= '0;
      end
      r_flags <= '0;
    end else if (w_en) begin
      r_tag[0]  <= in_tag;
      r_a[0]    <= in_a;
      r_bx[0]   <= in_b ^ {WIDTH{in_sub}};
      r_op[0]   <= alu_op_e'(in_sub);
      r_sign[0] <= in_sign;
      r_cin[0]  <= in_sub;
      for (int k = 1; k < STAGES; k++) begin
        r_a[k]    <= r_a[k-1];
        r_bx[k]   <= r_bx[k-1];
        r_op[k]   <= r_op[k-1];
        r_sign[k] <= r_sign[k-1];
        r_cin[k]  <= w_cout[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_tag[k+1] <= r_tag[k];
        r_lo[k+1]  <= w_ps[k];
      end
      r_flags <= w_flags;
    end
  end

  assign out_valid = r_vld[STAGES];
  assign out_s     = w_ps[STAGES];
  assign out_z     = r_flags.z;
  assign out_v     = r_flags.v;
  assign out_n     = r_flags.n;
  assign out_c     = r_flags.c;
  assign out_tag   = r_tag[STAGES];

endmodule

// File: tb/tb_alu_adder_pipe.sv
// Bench for alu_adder_pipe (WIDTH=32, STAGES=2, TAG_W=5).
// Expected results come from an arithmetic model of add/sub semantics; a
// negedge process compares every consumed output against the model queue.
module tb_alu_adder_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int EW     = TAG_W + 4 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic flush     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_sub    = 1'b0;
  logic in_sign   = 1'b0;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] in_a   = '0;
  logic [WIDTH-1:0] in_b   = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_s;
  logic             out_z, out_v, out_n, out_c;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  alu_adder_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sign   (in_sign),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_z     (out_z),
    .out_v     (out_v),
    .out_n     (out_n),
    .out_c     (out_c),
    .out_tag   (out_tag)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  // Packed as {tag, z, v, n, c, s}.
  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic sign,
                                          input logic [TAG_W-1:0] tag);
    logic [31:0] s;
    logic [32:0] wide;
    logic        z, v, n, c;
    longint      sa, sb, sr;
    if (sub) begin
      s = a - b;
      c = (a >= b);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s    = wide[31:0];
      c    = wide[32];
    end
    z = (s == 32'd0);
    if (sign) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = sub ? (sa - sb) : (sa + sb);
      v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      n  = (sr < 0);
    end else if (sub) begin
      v = (a < b);
      n = (a < b);
    end else begin
      v = c;
      n = 1'b0;
    end
    return {tag, z, v, n, c, s};
  endfunction

  task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic sign,
                     input logic [3:0] zvnc, input logic [31:0] s);
    logic [EW-1:0] want;
    want = {{TAG_W{1'b0}}, zvnc, s};
    check(name, model(a, b, sub, sign, '0), want);
  endtask

  // ---------------- scoreboard / compare ----------------
  logic          hold_pending = 1'b0;
  logic [EW-1:0] hold_val;

  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {out_tag, out_z, out_v, out_n, out_c, out_s};
    if (reset) begin
      if (hold_pending) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", got, hold_val);
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_result", got, e);
        end
      end
      if (out_valid && !out_ready && !flush) begin
        hold_pending = 1'b1;
        hold_val     = got;
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub, in_sign, in_tag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic sign, input logic [TAG_W-1:0] tag);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_sign  = sign;
    in_tag   = tag;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Call right after send() returns; counts edges from acceptance to out_valid.
  task automatic expect_latency(input string name, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!seen) lat = -1;
    check(name, lat, exp_lat);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Model pins against hand-computed values.
    pin("pin_sadd_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 4'b0100, 32'h80000000);
    pin("pin_usub_lt",   32'h00000003, 32'h00000005, 1'b1, 1'b0, 4'b0110, 32'hFFFFFFFE);
    pin("pin_usub_eq",   32'h00000005, 32'h00000005, 1'b1, 1'b0, 4'b1001, 32'h00000000);
    pin("pin_uadd_seg",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 4'b0000, 32'h00010000);
    pin("pin_uadd_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'b1101, 32'h00000000);
    pin("pin_ssub_ovf",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 4'b0111, 32'h7FFFFFFF);
    pin("pin_sadd_min",  32'h80000000, 32'h80000000, 1'b0, 1'b1, 4'b1111, 32'h00000000);

    // Reset state.
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {out_z, out_v, out_n, out_c}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Signed overflow add with latency and literal output checks.
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 5'd1);
    expect_latency("lat_sadd", STAGES);
    check("t1_s", out_s, 32'h80000000);
    check("t1_flags_zvnc", {out_z, out_v, out_n, out_c}, 4'b0100);
    check("t1_tag", out_tag, 5'd1);
    drain();

    // Unsigned subtracts, segment-boundary carry, wraparound, signed cases.
    send(32'd3, 32'd5, 1'b1, 1'b0, 5'd2);
    send(32'd5, 32'd5, 1'b1, 1'b0, 5'd3);
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 5'd4);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd5);
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 5'd6);
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1, 5'd7);
    send(32'h00000001, 32'h00000002, 1'b1, 1'b1, 5'd8);
    send(32'h80000000, 32'h80000000, 1'b0, 1'b1, 5'd9);
    send(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 5'd10);
    drain();
    check("seq_drained", exp_q.size(), 0);

    // Backpressure: four back-to-back ops, consumer stalls 3 cycles.
    fork
      begin
        send(32'd10, 32'd20, 1'b0, 1'b0, 5'd1);
        send(32'd30, 32'd40, 1'b0, 1'b0, 5'd2);
        send(32'hFFFF0000, 32'h00010000, 1'b0, 1'b0, 5'd3);
        send(32'd7, 32'd9, 1'b1, 1'b1, 5'd4);
      end
      begin
        bit seen;
        seen = 0;
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1;
            break;
          end
        end
        check("bp_first_out", seen, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_drained", exp_q.size(), 0);

    // Flush with two ops in flight and a simultaneous offer.
    send(32'd100, 32'd1, 1'b0, 1'b0, 5'd10);
    send(32'd200, 32'd2, 1'b0, 1'b0, 5'd11);
    in_valid = 1'b1;
    in_a     = 32'd300;
    in_b     = 32'd3;
    in_sub   = 1'b0;
    in_sign  = 1'b0;
    in_tag   = 5'd12;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("flush_out_valid_low", out_valid, 0);
      @(posedge clk);
    end
    #1;
    send(32'd400, 32'd4, 1'b1, 1'b0, 5'd13);
    expect_latency("lat_after_flush", STAGES);
    check("flush_next_tag", out_tag, 5'd13);
    drain();

    // Asynchronous reset while a result is on the output.
    send(32'd1, 32'd1, 1'b0, 1'b0, 5'd20);
    send(32'd2, 32'd2, 1'b0, 1'b0, 5'd21);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("arst_pre_valid", out_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_s", out_s, 0);
    check("arst_out_tag", out_tag, 0);
    check("arst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("arst_no_resume", out_valid, 0);
    @(posedge clk);
    #1;
    send(32'hAAAA5555, 32'h5555AAAB, 1'b0, 1'b0, 5'd22);
    expect_latency("lat_after_reset", STAGES);
    check("arst_next_s", out_s, 32'h00000000);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
